tb_tcdm_banked: RTL
===================

Name: tb_tcdm_banked

Overview:
- Parametrised, banked successor to the single-cycle testbench TCDM model.
- Serves MP hwpe_stream_intf_tcdm slave ports from a byte-addressed memory that is word-interleaved across NB banks.
- Adds per-bank round-robin arbitration with real bank conflicts, a configurable read latency pipeline, out-of-range error handling and access counters.
- Sits in the testbench between the DUT's TCDM master ports and the preloaded stimulus memory.

Parameters:
- MP, 4: number of TCDM slave ports.
- NB, 8: number of banks, power of two, ≥1.
- MEMORY_SIZE, 65536: memory size in bytes, multiple of 4*NB.
- BASE_ADDR, 0: byte address mapped to memory index 0.
- LATENCY, 1: cycles from grant to r_valid, ≥1.
- LFSR_SEED, 16'hACE1: stall LFSR seed, port i uses LFSR_SEED^i; only used with TCDM_STALL_EN.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- enable_i  input  1  global enable; 0 blocks all new grants.
- tcdm  slave  MP x hwpe_stream_intf_tcdm  request/response ports (req, gnt, add, wen, be, data, r_data, r_valid).
- cnt_rd_o  output  32  granted reads, total.
- cnt_wr_o  output  32  granted writes, total.
- cnt_conflict_o  output  32  cycles × ports that requested but were not granted.
- cnt_err_o  output  32  granted out-of-range accesses.

Behaviour:
- Address decode:
  - word = (add - BASE_ADDR) >> 2; add[1:0] is ignored, so all accesses are word-aligned.
  - bank = word % NB.
  - In range iff (add - BASE_ADDR) < MEMORY_SIZE, computed unsigned.
- Arbitration (combinational, same cycle):
  - Per bank, among ports with req=1 targeting it, at most one gnt.
  - Round-robin: the search starts at (last granted port for that bank)+1 mod MP; a bank's pointer updates only when that bank grants.
  - gnt=0 for all ports when enable_i=0.
- Writes (wen=0, granted): bytes with be[k]=1 are written at clock edge; other bytes are unchanged.
- Reads (wen=1, granted): the word is sampled at the grant edge.
- Same-cycle write and read to one word cannot both be granted (same bank). A read granted the cycle after a write returns the new data.
- Response pipeline:
  - Per port, LATENCY-deep shift register of {valid, data}.
  - r_valid=1 exactly LATENCY cycles after the grant cycle, r_data = read word; for writes, r_data = merged written word.
  - r_valid=0 and r_data=0 otherwise.
  - Back-to-back grants give back-to-back r_valid, in order, one per cycle.
- Out of range, granted:
  - Write is dropped.
  - Read returns 32'hDEADBEEF.
  - cnt_err_o increments; r_valid still asserted per the latency rule.
- enable_i=0 mid-operation: in-flight responses still drain on schedule.
- Counters: increment by the number of ports qualifying that cycle; saturate at 32'hFFFFFFFF.
- Reset (rst_ni=0 at edge):
  - Pipelines, r_valid, r_data, counters and RR pointers (all point to port MP-1, so port 0 has first priority) are cleared.
  - Memory contents are retained (preloaded by the bench).
  - Responses in flight during reset are discarded.

Optional Feature:
- TCDM_STALL_EN defined:
  - Each port has a 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced every cycle, reset to its seed.
  - Grant is masked when lfsr[1:0]==2'b00 (~25% random stall).
  - A masked request counts as a conflict and does not advance the RR pointer.
- Not defined: no LFSR logic, grants depend only on arbitration and enable_i.

Test Plan:
- Latency: LATENCY=3; port 0 write 32'h11223344 to BASE_ADDR+0x40 (be=4'hF), then read it → gnt same cycle, r_valid exactly 3 cycles after each grant, read r_data=32'h11223344.
- Byte enables: preload word 0xAABBCCDD, write data 0x00000011, be=4'b0001 → subsequent read returns 0xAABBCC11.
- Bank conflict: NB=8, ports 0–3 all read address 0x00 for 4 cycles → one grant per cycle in order 0,1,2,3; cnt_conflict_o=6 after those cycles.
- Different banks: 4 ports read 0x00, 0x04, 0x08, 0x0C in one cycle → all 4 granted, cnt_rd_o=4, no conflict.
- Out of range: read at BASE_ADDR+MEMORY_SIZE → r_data=32'hDEADBEEF, cnt_err_o=1; write there leaves memory unchanged.
- Reset: assert rst_ni=0 one cycle with a read in flight (LATENCY=2) → no r_valid afterwards, counters 0, memory unchanged.

Source files
------------

// File: rtl/tb_tcdm_banked_if.sv
// tb_tcdm_banked_if: MP-port TCDM request/response bundle (req, gnt, add, wen, be, data, r_data, r_valid)
interface tb_tcdm_banked_if #(
  parameter int MP = 4
);
  logic [MP-1:0]       req, gnt, wen, r_valid;
  logic [MP-1:0][31:0] add, data, r_data;
  logic [MP-1:0][3:0]  be;
  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tb_tcdm_banked.sv
// tb_tcdm_banked: word-interleaved banked TCDM model with per-bank round-robin, latency pipe and counters; define TCDM_STALL_EN for random LFSR stalls
module tb_tcdm_banked #(
  parameter int          MP          = 4,
  parameter int          NB          = 8,
  parameter int          MEMORY_SIZE = 65536,
  parameter logic [31:0] BASE_ADDR   = '0,
  parameter int          LATENCY     = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  tb_tcdm_banked_if.slave tcdm,
  output logic [31:0]     cnt_rd_o,
  output logic [31:0]     cnt_wr_o,
  output logic [31:0]     cnt_conflict_o,
  output logic [31:0]     cnt_err_o
);
  localparam int WORDS = MEMORY_SIZE / 4;
  localparam int AW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = MP > 1 ? $clog2(MP) : 1;
  logic [31:0]         mem [WORDS];
  logic [31:0]         off [MP];
  logic [31:0]         rsp [MP];
  logic [BW-1:0]       bank [MP];
  logic [AW-1:0]       idx [MP];
  logic [MP-1:0]       inr, avail, gnt;
  logic [NB-1:0]       hit;
  logic [PW-1:0]       ptr_q [NB];
  logic [PW-1:0]       ptr_d [NB];
  logic [MP-1:0]       vld_q [LATENCY];
  logic [MP-1:0][31:0] dat_q [LATENCY];
  logic [3:0][31:0]    cnt_q;
  function automatic int nxt(input logic [PW-1:0] q, input int k);
    return (int'(q) + k) % MP;
  endfunction
  function automatic logic [31:0] sat(input logic [31:0] c, input logic [MP-1:0] v);
    logic [32:0] s;
    s = {1'b0, c} + 33'($countones(v));
    return s[32] ? '1 : s[31:0];
  endfunction
  // Address decode and response word: read data, byte-merged write data, or the error pattern
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      off[p] = tcdm.add[p] - BASE_ADDR;
      inr[p] = off[p] < 32'(MEMORY_SIZE);
      bank[p] = NB > 1 ? off[p][2 +: BW] : '0;
      idx[p] = off[p][2 +: AW];
      rsp[p] = mem[idx[p]];
      for (int k = 0; k < 4; k++)
        if (!tcdm.wen[p] && tcdm.be[p][k]) rsp[p][8*k +: 8] = tcdm.data[p][8*k +: 8];
      if (!inr[p]) rsp[p] = 32'hDEADBEEF;
    end
  end
`ifdef TCDM_STALL_EN
  logic [15:0] lfsr_q [MP];
  // Per-port Fibonacci LFSR (taps 16,14,13,11) stepping every cycle from its own seed
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++)
      lfsr_q[p] <= !rst_ni ? LFSR_SEED ^ 16'(p)
                           : {lfsr_q[p][14:0], lfsr_q[p][15] ^ lfsr_q[p][13] ^ lfsr_q[p][12] ^ lfsr_q[p][10]};
  end
  // A port is stalled for the cycle when its LFSR low bits are both zero
  always_comb begin
    for (int p = 0; p < MP; p++) avail[p] = lfsr_q[p][1:0] != 2'b00;
  end
`else
  assign avail = '1;
`endif
  // Per-bank round-robin: first eligible port after the bank's last winner gets the grant
  always_comb begin
    gnt = '0;
    hit = '0;
    ptr_d = ptr_q;
    for (int b = 0; b < NB; b++)
      for (int k = 1; k <= MP; k++)
        if (enable_i && rst_ni && !hit[b] && tcdm.req[nxt(ptr_q[b], k)] && avail[nxt(ptr_q[b], k)]
            && bank[nxt(ptr_q[b], k)] == BW'(b)) begin
          hit[b] = 1'b1;
          gnt[nxt(ptr_q[b], k)] = 1'b1;
          ptr_d[b] = PW'(nxt(ptr_q[b], k));
        end
  end
  // RR pointers, response shift registers and saturating access counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < NB; b++) ptr_q[b] <= PW'(MP - 1);
      for (int s = 0; s < LATENCY; s++) begin
        vld_q[s] <= '0;
        dat_q[s] <= '0;
      end
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int s = LATENCY - 1; s > 0; s--) begin
        vld_q[s] <= vld_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
      vld_q[0] <= gnt;
      for (int p = 0; p < MP; p++) dat_q[0][p] <= gnt[p] ? rsp[p] : '0;
      cnt_q[0] <= sat(cnt_q[0], gnt & tcdm.wen);
      cnt_q[1] <= sat(cnt_q[1], gnt & ~tcdm.wen);
      cnt_q[2] <= sat(cnt_q[2], tcdm.req & ~gnt);
      cnt_q[3] <= sat(cnt_q[3], gnt & ~inr);
    end
  end
  // Granted in-range writes store the merged word; memory survives reset
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++)
      if (gnt[p] && !tcdm.wen[p] && inr[p]) mem[idx[p]] <= rsp[p];
  end
  assign tcdm.gnt = gnt;
  assign tcdm.r_valid = vld_q[LATENCY-1];
  assign tcdm.r_data = dat_q[LATENCY-1];
  assign cnt_rd_o = cnt_q[0];
  assign cnt_wr_o = cnt_q[1];
  assign cnt_conflict_o = cnt_q[2];
  assign cnt_err_o = cnt_q[3];
endmodule
